// File: rtl/l1_miss_refill_ctrl_if.sv
// Signal bundle between the L1 miss refill controller and its surroundings:
// miss request and victim info, victim data read, memory beat port, array write ports.
interface l1_miss_refill_ctrl_if #(
   parameter int index_bits         = 7,
   parameter int tag_bits           = 3,
   parameter int no_of_l2_ways_bits = 2,
   parameter int offset_bits        = 2,
   parameter int word_width         = 32
);
   localparam int addr_bits = tag_bits + index_bits + offset_bits;

   logic                          miss_req;
   logic [index_bits-1:0]         miss_index;
   logic [tag_bits-1:0]           miss_tag;
   logic [no_of_l2_ways_bits-1:0] LRU_block;
   logic                          victim_valid;
   logic                          victim_dirty;
   logic [tag_bits-1:0]           victim_tag;
   logic [offset_bits-1:0]        victim_rd_word;
   logic [word_width-1:0]         victim_rd_data;

   // Memory beats: a beat completes on any cycle with mem_req & mem_ready.
   // While mem_req=1 and mem_ready=0, mem_we/mem_addr/mem_wdata hold steady;
   // mem_ready seen while mem_req=0 has no effect.
   logic                          mem_req;
   logic                          mem_we;
   logic [addr_bits-1:0]          mem_addr;
   logic [word_width-1:0]         mem_wdata;
   logic                          mem_ready;
   logic [word_width-1:0]         mem_rdata;

   logic                          fill_we;
   logic [no_of_l2_ways_bits-1:0] fill_way;
   logic [index_bits-1:0]         fill_index;
   logic [offset_bits-1:0]        fill_word;
   logic [word_width-1:0]         fill_data;
   logic                          tag_we;
   logic [tag_bits-1:0]           tag_value;
   logic                          busy;
   logic                          miss_done;
   logic [1:0]                    dbg_state;

   modport master (
      input  miss_req, miss_index, miss_tag, LRU_block, victim_valid, victim_dirty,
             victim_tag, victim_rd_data, mem_ready, mem_rdata,
      output victim_rd_word, mem_req, mem_we, mem_addr, mem_wdata, fill_we, fill_way,
             fill_index, fill_word, fill_data, tag_we, tag_value, busy, miss_done, dbg_state
   );

   modport slave (
      output miss_req, miss_index, miss_tag, LRU_block, victim_valid, victim_dirty,
             victim_tag, victim_rd_data, mem_ready, mem_rdata,
      input  victim_rd_word, mem_req, mem_we, mem_addr, mem_wdata, fill_we, fill_way,
             fill_index, fill_word, fill_data, tag_we, tag_value, busy, miss_done, dbg_state
   );
endinterface

// File: rtl/l1_miss_refill_ctrl.sv
// L1 miss refill controller: latches the victim way on a miss, writes back a
// dirty victim, fills the line word by word from memory, then updates the tag.
module l1_miss_refill_ctrl #(
   parameter int index_bits         = 7,
   parameter int tag_bits           = 3,
   parameter int no_of_l2_ways_bits = 2,
   parameter int offset_bits        = 2,
   parameter int word_width         = 32
) (
   input logic             CLK,
   input logic             RST,
   l1_miss_refill_ctrl_if.master bus
);
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WB     = 2'd1,
      S_FILL   = 2'd2,
      S_UPDATE = 2'd3
   } state_t;

   localparam logic [offset_bits-1:0] CNT_LAST = '1;

   state_t                        r_state;
   state_t                        w_state_nxt;
   logic [offset_bits-1:0]        r_cnt;
   logic [index_bits-1:0]         r_index;
   logic [tag_bits-1:0]           r_tag;
   logic [tag_bits-1:0]           r_vtag;
   logic [no_of_l2_ways_bits-1:0] r_way;
   logic                          w_accept;
   logic                          w_beat;
   logic                          w_last;

   assign w_accept = (r_state == S_IDLE) && bus.miss_req;
   assign w_beat   = ((r_state == S_WB) || (r_state == S_FILL)) && bus.mem_ready;
   assign w_last   = (r_cnt == CNT_LAST);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // The word counter wraps naturally, so it is already 0 when WB hands over to FILL.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_cnt   <= '0;
         r_index <= '0;
         r_tag   <= '0;
         r_vtag  <= '0;
         r_way   <= '0;
      end else if (w_accept) begin
         r_cnt   <= '0;
         r_index <= bus.miss_index;
         r_tag   <= bus.miss_tag;
         r_vtag  <= bus.victim_tag;
         r_way   <= bus.LRU_block;
      end else if (w_beat) begin
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   always_comb begin
      w_state_nxt        = r_state;
      bus.victim_rd_word = '0;
      bus.mem_req        = 1'b0;
      bus.mem_we         = 1'b0;
      bus.mem_addr       = '0;
      bus.mem_wdata      = '0;
      bus.fill_we        = 1'b0;
      bus.fill_way       = r_way;
      bus.fill_index     = r_index;
      bus.fill_word      = '0;
      bus.fill_data      = '0;
      bus.tag_we         = 1'b0;
      bus.tag_value      = '0;
      bus.miss_done      = 1'b0;
      bus.busy           = (r_state != S_IDLE);
      bus.dbg_state      = r_state;

      case (r_state)
         S_IDLE: begin
            // An invalid victim never needs a writeback, whatever its dirty bit says.
            if (bus.miss_req)
               w_state_nxt = (bus.victim_valid && bus.victim_dirty) ? S_WB : S_FILL;
         end
         S_WB: begin
            bus.mem_req        = 1'b1;
            bus.mem_we         = 1'b1;
            bus.mem_addr       = {r_vtag, r_index, r_cnt};
            bus.victim_rd_word = r_cnt;
            bus.mem_wdata      = bus.victim_rd_data;
            if (bus.mem_ready && w_last) w_state_nxt = S_FILL;
         end
         S_FILL: begin
            bus.mem_req   = 1'b1;
            bus.mem_addr  = {r_tag, r_index, r_cnt};
            bus.fill_word = r_cnt;
            if (bus.mem_ready) begin
               bus.fill_we   = 1'b1;
               bus.fill_data = bus.mem_rdata;
               if (w_last) w_state_nxt = S_UPDATE;
            end
         end
         S_UPDATE: begin
            bus.tag_we    = 1'b1;
            bus.tag_value = r_tag;
            bus.miss_done = 1'b1;
            w_state_nxt   = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end
endmodule

// File: doc/l1_miss_refill_ctrl.md
Name: l1_miss_refill_ctrl

Overview:
Downstream consumer of the L1 replacement-way selector. On an L1 miss it latches the victim way (LRU_block), then runs the line replacement:
- optional dirty-victim writeback;
- line fill from the next memory level over a valid/ready word handshake;
- tag/valid update.
It drives the L1 data/tag array write ports and reports completion to the cache controller.

Parameters:
index_bits, 7, set index width (128 sets)
tag_bits, 3, tag width
no_of_l2_ways_bits, 2, way-select width (4 ways)
offset_bits, 2, log2 words per block (4 words)
word_width, 32, data word width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-low reset
miss_req  in  1  miss request, sampled in IDLE only
miss_index  in  index_bits  set of missing line
miss_tag  in  tag_bits  tag of missing line
LRU_block  in  no_of_l2_ways_bits  victim way from LRU selector, valid with miss_req
victim_valid  in  1  valid bit of victim line, valid with miss_req
victim_dirty  in  1  dirty bit of victim line, valid with miss_req
victim_tag  in  tag_bits  tag of victim line, valid with miss_req
victim_rd_word  out  offset_bits  word select into data array (combinational read)
victim_rd_data  in  word_width  data array word at {miss_index, victim way, victim_rd_word}
mem_req  out  1  memory beat request
mem_we  out  1  1 = write beat, 0 = read beat
mem_addr  out  tag_bits+index_bits+offset_bits  word address {tag, index, word}
mem_wdata  out  word_width  write data
mem_ready  in  1  beat accepted (write) / mem_rdata valid (read)
mem_rdata  in  word_width  read data
fill_we  out  1  data array write enable
fill_way  out  no_of_l2_ways_bits  way being written
fill_index  out  index_bits  set being written
fill_word  out  offset_bits  word being written
fill_data  out  word_width  data being written
tag_we  out  1  tag/valid write enable; sets valid=1, dirty=0
tag_value  out  tag_bits  new tag
busy  out  1  high in any state other than IDLE
miss_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (RST=0, async): state=IDLE, word counter=0, all latches=0; every output 0. Reset mid-operation abandons the transaction: no tag_we, no further beats.
- FSM states: IDLE, WB, FILL, UPDATE.
- IDLE, miss_req=1:
  - latch miss_index, miss_tag, LRU_block, victim_tag, and dirty_wb = victim_valid & victim_dirty;
  - clear word counter;
  - next state = WB if dirty_wb, else FILL.
- miss_req in any non-IDLE state is ignored; no queuing. The requester must hold it until miss_done.
- WB:
  - mem_req=1, mem_we=1;
  - mem_addr = {victim_tag_l, index_l, cnt};
  - victim_rd_word=cnt; mem_wdata=victim_rd_data.
  - Beat completes on a cycle with mem_req & mem_ready. cnt increments, wrapping at 2^offset_bits.
  - After the last word (cnt = all-ones, accepted): cnt=0, go to FILL.
- FILL:
  - mem_req=1, mem_we=0, mem_addr = {tag_l, index_l, cnt}.
  - On mem_ready, in the same cycle: fill_we=1, fill_way=way_l, fill_index=index_l, fill_word=cnt, fill_data=mem_rdata; then cnt increments.
  - After the last word: go to UPDATE.
- UPDATE (exactly 1 cycle): tag_we=1, tag_value=tag_l, fill_way/fill_index held, miss_done=1; next state IDLE.
- Handshake rules:
  - mem_addr, mem_wdata and mem_we are stable while mem_req=1 and mem_ready=0.
  - mem_req stays high across consecutive beats.
  - mem_ready while mem_req=0 is ignored.
- Outputs in IDLE:
  - fill_we, tag_we, mem_req, miss_done, busy = 0;
  - fill_way and fill_index hold their last latched values (don't-care).
- Latency with mem_ready tied high:
  - clean or invalid victim: miss_req sampled at edge 0; FILL beats in cycles 1-4; UPDATE/miss_done in cycle 5; IDLE in cycle 6.
  - dirty victim: add 4 cycles.
- Each mem_ready stall cycle adds one cycle.
- Invalid victim with dirty=1 is treated as clean (no writeback).
- A new miss_req is accepted in the cycle immediately after miss_done.

Test Plan:
1. Clean miss: index=5, tag=3, LRU_block=2, victim_dirty=0, mem_ready=1, mem_rdata=0xA0..0xA3 -> 4 read beats at addr {3,5,0..3}; fill_we on way 2 words 0-3 with 0xA0-0xA3; tag_we with tag 3 and miss_done in cycle 5; busy low in cycle 6.
2. Dirty miss: victim_valid=1, victim_dirty=1, victim_tag=6, victim words 0x10-0x13 -> 4 write beats at {6,idx,0..3} carrying 0x10-0x13, then 4 fill reads; miss_done in cycle 9.
3. Stalls: mem_ready low for 2 cycles on each beat of a clean miss -> addr stable while stalled; miss_done in cycle 13; exactly 4 fill_we pulses.
4. Invalid-but-dirty victim (valid=0, dirty=1) -> no write beats; timing as scenario 1.
5. miss_req pulsed again while busy with a different index -> ignored; latched index unchanged; exactly one miss_done.
6. RST low during WB beat 2 -> all outputs 0 immediately; after release, state IDLE with no tag_we; a fresh miss completes normally.
